// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions: transfer/response/size/burst encodings, bus
// widths, the command-master FSM state encoding and a size/alignment check.
// Also imported by the AHB register slaves.
package ahb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } ahb_mst_state_e;

  // True when a command may not go on the bus: illegal size or unaligned address.
  function automatic logic cmd_illegal(input logic [1:0] size, input logic [1:0] lsb);
    logic bad;
    case (size)
      2'd0:    bad = 1'b0;
      2'd1:    bad = lsb[0];
      2'd2:    bad = |lsb;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb_cmd_master_if.sv
// AHB-Lite single-master bus bundle.
// master modport: drives haddr/htrans/hwrite/hsize/hburst/hwdata, samples hready/hrdata/hresp.
// slave modport:  the mirror image.
interface ahb_cmd_master_if;
  import ahb_pkg::*;

  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic [DATA_W-1:0] hrdata;
  logic [1:0]        hresp;

  modport master (
    output haddr, htrans, hwrite, hsize, hburst, hwdata,
    input  hready, hrdata, hresp
  );

  modport slave (
    input  haddr, htrans, hwrite, hsize, hburst, hwdata,
    output hready, hrdata, hresp
  );

endinterface

// File: rtl/ahb_cmd_master_timeout_ctr.sv
// ahb_timeout_ctr: counts consecutive stalled cycles and flags the cycle on
// which the TIMEOUT_CYCLES-th stall occurs.
// Ports: hclk/hresetn, clear (zero the count), enable (stall this cycle),
// expired_c (combinational: this stall is the last one allowed).
// TIMEOUT_CYCLES = 0 disables the counter entirely.
module ahb_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_W           = 16
) (
  input  logic hclk,
  input  logic hresetn,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic        ON   = (TIMEOUT_CYCLES != 0);

  logic [TO_W-1:0] count;

  // Stall counter; held at zero when the timeout is disabled.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)
      count <= '0;
    else if (clear || !ON)
      count <= '0;
    else if (enable)
      count <= count + TO_W'(1);
  end

  assign expired_c = ON && enable && (count == TO_W'(LAST));

endmodule

// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: turns valid/ready commands into non-pipelined AHB-Lite
// SINGLE transfers and returns read data / error status on a valid/ready
// response channel. One transfer in flight at a time.
// Ports: hclk/hresetn; cmd_* command channel (cmd_ready combinational, IDLE only);
// rsp_* response channel; bus (AHB master side); busy (not IDLE).
module ahb_cmd_master
  import ahb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_W           = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [1:0]        cmd_size,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  ahb_cmd_master_if.master  bus,
  output logic              busy
);

  ahb_mst_state_e    state;
  logic [DATA_W-1:0] wdata_q;
  logic              stall;
  logic              to_expired_c;

  assign cmd_ready  = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);
  assign bus.hburst = HBURST_SINGLE;

  // Stall = hready low while the transfer owns the bus.
  assign stall = ((state == ST_ADDR) || (state == ST_DATA)) && !bus.hready;

  ahb_timeout_ctr #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_W           (TO_W)
  ) u_timeout (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .clear     (!stall),
    .enable    (stall),
    .expired_c (to_expired_c)
  );

  // Transfer FSM with registered bus and response outputs.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state       <= ST_IDLE;
      bus.htrans  <= HTRANS_IDLE;
      bus.haddr   <= '0;
      bus.hwrite  <= 1'b0;
      bus.hsize   <= '0;
      bus.hwdata  <= '0;
      wdata_q     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            wdata_q     <= cmd_wdata;
            rsp_timeout <= 1'b0;
            if (cmd_illegal(cmd_size, cmd_addr[1:0])) begin
              // Rejected locally; the bus never sees it.
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state      <= ST_ADDR;
              bus.htrans <= HTRANS_NONSEQ;
              bus.haddr  <= cmd_addr;
              bus.hwrite <= cmd_write;
              bus.hsize  <= {1'b0, cmd_size};
            end
          end
        end

        ST_ADDR: begin
          if (bus.hready) begin
            state      <= ST_DATA;
            bus.htrans <= HTRANS_IDLE;
            bus.hwdata <= wdata_q;
          end else if (to_expired_c) begin
            state       <= ST_RESP;
            bus.htrans  <= HTRANS_IDLE;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end
        end

        ST_DATA: begin
          // The first ERROR cycle has hready low and needs no action: htrans is already IDLE.
          if (bus.hready) begin
            state       <= ST_RESP;
            rsp_valid   <= 1'b1;
            rsp_err     <= (bus.hresp == HRESP_ERROR);
            rsp_timeout <= 1'b0;
            rsp_rdata   <= (!bus.hwrite && (bus.hresp == HRESP_OKAY)) ? bus.hrdata : '0;
          end else if (to_expired_c) begin
            state       <= ST_RESP;
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= '0;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
